debounce_multi: RTL and testbench
=================================

Name: debounce_multi

Overview:
- Parametrised multi-channel debouncer; successor to the single-button debounce FSM.
- Per channel: input synchroniser, counter-based stability window, debounced level output, one-cycle press and release pulses, and an optional long-press pulse.
- Sits between raw board buttons/switches and the counter/control logic.
- All channels are identical and independent and share one clock.

Parameters:
- N_CH, 4: number of independent button channels.
- STABLE_CYCLES, 16: consecutive identical synchronised samples required to accept an edge (>=2).
- SYNC_STAGES, 2: synchroniser flop depth (>=2).
- LONG_CYCLES, 0: cycles in PRESSED before the long-press pulse; 0 disables the feature (long stays 0).
- ACTIVE_LOW, 0: 1 inverts the raw inputs before synchronisation (for pull-up buttons).

Ports:
- ck  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state immediately.
- button  in  N_CH  raw asynchronous button inputs.
- level  out  N_CH  debounced button state, 1 = pressed.
- push  out  N_CH  one-cycle pulse on accepted press.
- release  out  N_CH  one-cycle pulse on accepted release.
- long  out  N_CH  one-cycle pulse when a press has been held LONG_CYCLES cycles.

Behaviour:
- Reset (reset=0): synchroniser flops, counters and hold counters go to 0; every channel enters state RELEASED; level, push, release and long are 0. Reset is asynchronous both on assertion and mid-operation. After release of reset, no pulse is generated until a full window has elapsed.
- Outputs: all outputs are registered; no combinational path from button to any output.
- Synchroniser: each bit passes through SYNC_STAGES flops (after optional inversion). s[i] is the final-stage output.
- Counters: stability counter width is clog2(STABLE_CYCLES+1). Hold counter width is clog2(LONG_CYCLES+1), minimum 1. Neither counter wraps: the stability counter is cleared on every state change; the hold counter saturates.
- Per-channel FSM, 4 states:
  - RELEASED (level=0): s=1 -> PRESS_WAIT with cnt=1; otherwise stay.
  - PRESS_WAIT (level=0): s=0 -> RELEASED, cnt=0, no pulse. s=1 with cnt=STABLE_CYCLES-1 -> PRESSED; level<=1, push<=1 for one cycle; hold counter<=0. s=1 otherwise -> cnt++.
  - PRESSED (level=1): s=0 -> RELEASE_WAIT with cnt=1. Each cycle with LONG_CYCLES>0, the hold counter increments while below LONG_CYCLES; the cycle it reaches LONG_CYCLES, long<=1 for one cycle. long fires only once per press and never again until the next accepted push.
  - RELEASE_WAIT (level=1): s=1 -> PRESSED, cnt=0, hold counter preserved and keeps counting. s=0 with cnt=STABLE_CYCLES-1 -> RELEASED; level<=0, release<=1 for one cycle. s=0 otherwise -> cnt++.
- Latency:
  - Count as edge 1 the first rising edge of ck sampling a steady raw 1.
  - push and level rise after edge SYNC_STAGES+STABLE_CYCLES.
  - Release latency is symmetric.
  - long rises LONG_CYCLES edges after push rises.
- Glitch rejection: any run shorter than STABLE_CYCLES synchronised samples, including sub-cycle bounces, produces no level change and no pulse.
- Pulse exclusivity: push, release and long on one channel are never high in the same cycle. Whether long and release can coincide is also resolved: a transition to RELEASED suppresses a long due in that cycle.
- Channels: channels are fully independent; simultaneous events on different channels all produce their pulses in the same cycle.

Test Plan:
- Reset with N_CH=4, STABLE_CYCLES=4, SYNC_STAGES=2, LONG_CYCLES=20, ck period 10 ns: hold reset=0 with button=4'hF -> level, push, release and long all 0 for the whole reset. Deassert reset with button held -> push=4'hF exactly once, 6 edges after the first edge following release of reset.
- Clean press: button[0] 0->1 and held -> push[0]=1 for exactly one cycle after edge 6. level[0]=1 from the same edge. Other channels stay 0.
- Bounce: toggle button[1] every 1 ns for 5 ns, then every cycle for 10 cycles, then hold 0 -> no push[1] or release[1]; level[1] stays 0. Repeat with the final value 1 -> exactly one push[1], 6 edges after settling.
- Short pulse: button[2]=1 for 3 cycles, then 0 -> filtered, all outputs 0. Then in PRESSED, drop button[2] for 3 cycles and restore -> no release[2]; level stays 1.
- Long press and release: press button[3] and hold 30 cycles -> push[3], then long[3] exactly 20 cycles later, once only. Drop the button -> release[3] one cycle after edge 6 of the drop; level[3]=0.
- Async reset mid-window: assert reset=0 between ck edges while channel 0 is in PRESS_WAIT with cnt=2 -> level and cnt clear immediately without waiting for a ck edge. After reset deasserts with button held, push[0] needs the full 6 edges.

Source files
------------

// File: rtl/debounce_multi.sv
// Multi-channel button debouncer.
// Each channel: optional inversion, SYNC_STAGES-deep synchroniser, and a four-state
// stability FSM producing a registered level plus one-cycle push / release / long pulses.
// All outputs come straight from flops.
module debounce_multi #(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned LONG_CYCLES   = 0,
  parameter bit          ACTIVE_LOW    = 1'b0
) (
  input  logic            ck,
  input  logic            reset,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] push,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long
);

  localparam int unsigned CntW  = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned HoldW = (LONG_CYCLES > 0) ? $clog2(LONG_CYCLES + 1) : 1;

  localparam logic [CntW-1:0]  CntLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(LONG_CYCLES);

  typedef enum logic [1:0] {
    StReleased,
    StPressWait,
    StPressed,
    StReleaseWait
  } state_e;

  logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q, sync_d;
  logic [N_CH-1:0]                  s;

  state_e           state_q [N_CH];
  state_e           state_d [N_CH];
  logic [CntW-1:0]  cnt_q   [N_CH];
  logic [CntW-1:0]  cnt_d   [N_CH];
  logic [HoldW-1:0] hold_q  [N_CH];
  logic [HoldW-1:0] hold_d  [N_CH];

  logic [N_CH-1:0] level_q, level_d;
  logic [N_CH-1:0] push_q, push_d;
  logic [N_CH-1:0] rel_q, rel_d;
  logic [N_CH-1:0] long_q, long_d;

  // Synchroniser shift: stage 0 takes the (optionally inverted) raw input.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], (ACTIVE_LOW ? ~button : button)};
    s      = sync_q[SYNC_STAGES-1];
  end

  // Per-channel stability FSM, hold counter and pulse generation.
  always_comb begin
    logic long_due;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      hold_d[i]  = hold_q[i];
      level_d[i] = level_q[i];
      push_d[i]  = 1'b0;
      rel_d[i]   = 1'b0;
      long_due   = 1'b0;

      // Hold time keeps accruing through a tentative release (RELEASE_WAIT).
      if ((state_q[i] == StPressed || state_q[i] == StReleaseWait) && LONG_CYCLES != 0 &&
          hold_q[i] != HoldMax) begin
        hold_d[i] = hold_q[i] + 1'b1;
        long_due  = (hold_d[i] == HoldMax);
      end

      unique case (state_q[i])
        StReleased: begin
          if (s[i]) begin
            state_d[i] = StPressWait;
            cnt_d[i]   = CntW'(1);
          end
        end
        StPressWait: begin
          if (!s[i]) begin
            state_d[i] = StReleased;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntLast) begin
            state_d[i] = StPressed;
            cnt_d[i]   = '0;
            level_d[i] = 1'b1;
            push_d[i]  = 1'b1;
            hold_d[i]  = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        StPressed: begin
          if (!s[i]) begin
            state_d[i] = StReleaseWait;
            cnt_d[i]   = CntW'(1);
          end
        end
        StReleaseWait: begin
          if (s[i]) begin
            state_d[i] = StPressed;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntLast) begin
            state_d[i] = StReleased;
            cnt_d[i]   = '0;
            level_d[i] = 1'b0;
            rel_d[i]   = 1'b1;
            long_due   = 1'b0;  // an accepted release wins over a long due now
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = StReleased;
          cnt_d[i]   = '0;
        end
      endcase

      long_d[i] = long_due;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      level_q <= '0;
      push_q  <= '0;
      rel_q   <= '0;
      long_q  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= StReleased;
        cnt_q[i]   <= '0;
        hold_q[i]  <= '0;
      end
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      push_q  <= push_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        hold_q[i]  <= hold_d[i];
      end
    end
  end

  assign level         = level_q;
  assign push          = push_q;
  assign release_pulse = rel_q;
  assign long          = long_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: directed scenarios plus random stimulus, checked every cycle
// against a run-length model of the debouncing rules.
module tb_debounce_multi;

  localparam int N  = 4;
  localparam int ST = 4;
  localparam int SY = 2;
  localparam int LG = 20;

  logic         ck = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] button = '0;
  logic [N-1:0] level, push, release_pulse, long;

  debounce_multi #(
    .N_CH         (N),
    .STABLE_CYCLES(ST),
    .SYNC_STAGES  (SY),
    .LONG_CYCLES  (LG),
    .ACTIVE_LOW   (1'b0)
  ) dut (
    .ck           (ck),
    .reset        (reset),
    .button       (button),
    .level        (level),
    .push         (push),
    .release_pulse(release_pulse),
    .long         (long)
  );

  always #5 ck = ~ck;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model state: raw-sample delay line, run of samples disagreeing with the level,
  // and edges elapsed since the last accepted push.
  logic [SY-1:0] hist [N];
  int            run [N];
  int            since [N];
  logic [N-1:0]  exp_level = '0, exp_push = '0, exp_rel = '0, exp_long = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic void model_step();
    logic s;
    logic was;
    for (int c = 0; c < N; c++) begin
      exp_push[c] = 1'b0;
      exp_rel[c]  = 1'b0;
      exp_long[c] = 1'b0;
      if (!reset) begin
        hist[c]      = '0;
        run[c]       = 0;
        since[c]     = 0;
        exp_level[c] = 1'b0;
      end else begin
        s = hist[c][SY-1];
        for (int k = SY - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = button[c];
        was = exp_level[c];
        if (s != was) begin
          run[c]++;
          if (run[c] == ST) begin
            run[c]       = 0;
            exp_level[c] = s;
            if (s) begin
              exp_push[c] = 1'b1;
              since[c]    = 0;
            end else begin
              exp_rel[c] = 1'b1;
            end
          end
        end else begin
          run[c] = 0;
        end
        if (was && exp_level[c] && since[c] < LG) begin
          since[c]++;
          if (since[c] == LG) exp_long[c] = 1'b1;
        end
      end
    end
  endfunction

  // One clock: the model takes the same sample as the DUT, outputs compared 1 ns later.
  task automatic tick();
    @(posedge ck);
    cyc++;
    model_step();
    #1;
    check("level", 32'(level), 32'(exp_level));
    check("push", 32'(push), 32'(exp_push));
    check("release", 32'(release_pulse), 32'(exp_rel));
    check("long", 32'(long), 32'(exp_long));
  endtask

  int p_at, l_at, nlong, cnt;
  int hold_left [N];

  initial begin
    for (int c = 0; c < N; c++) begin
      hist[c] = '0; run[c] = 0; since[c] = 0; hold_left[c] = 0;
    end

    // Reset held with all buttons pressed.
    button = 4'hF;
    repeat (4) tick();
    @(negedge ck);
    reset = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 5) check("rst_push_early", 32'(push), 0);
    end
    check("rst_push", 32'(push), 32'hF);
    check("rst_level", 32'(level), 32'hF);
    tick();
    check("rst_push_once", 32'(push), 0);
    button = '0;
    repeat (12) tick();
    check("rst_all_released", 32'(level), 0);

    // Clean press on channel 0.
    button[0] = 1'b1;
    repeat (5) tick();
    check("clean_push_early", 32'(push), 0);
    tick();
    check("clean_push", 32'(push), 32'h1);
    check("clean_level", 32'(level), 32'h1);
    tick();
    check("clean_push_once", 32'(push), 0);
    button[0] = 1'b0;
    repeat (10) tick();

    // Bounce on channel 1, settling at 0 then at 1.
    for (int v = 0; v < 2; v++) begin
      cnt = 0;
      for (int k = 0; k < 5; k++) begin
        #1 button[1] = ~button[1];
      end
      for (int k = 0; k < 10; k++) begin
        tick();
        cnt += int'(push[1]) + int'(release_pulse[1]) + int'(level[1]);
        button[1] = ~button[1];
      end
      button[1] = 1'b0;
      tick();
      cnt += int'(push[1]) + int'(release_pulse[1]) + int'(level[1]);
      if (v == 0) begin
        repeat (10) begin
          tick();
          cnt += int'(push[1]) + int'(release_pulse[1]) + int'(level[1]);
        end
        check("bounce0_quiet", 32'(cnt), 0);
      end else begin
        check("bounce1_quiet", 32'(cnt), 0);
        button[1] = 1'b1;
        repeat (5) tick();
        check("bounce1_push_early", 32'(push), 0);
        tick();
        check("bounce1_push", 32'(push), 32'h2);
        button[1] = 1'b0;
        repeat (10) tick();
      end
    end

    // Short pulse on channel 2, then a short dropout while pressed.
    cnt = 0;
    button[2] = 1'b1;
    repeat (3) begin tick(); cnt += int'(push[2]) + int'(level[2]); end
    button[2] = 1'b0;
    repeat (10) begin tick(); cnt += int'(push[2]) + int'(level[2]); end
    check("short_filtered", 32'(cnt), 0);
    button[2] = 1'b1;
    repeat (8) tick();
    check("short_pressed", 32'(level[2]), 1);
    cnt = 0;
    button[2] = 1'b0;
    repeat (3) begin tick(); cnt += int'(release_pulse[2]); end
    button[2] = 1'b1;
    repeat (6) begin tick(); cnt += int'(release_pulse[2]); end
    check("dropout_no_release", 32'(cnt), 0);
    check("dropout_level", 32'(level[2]), 1);
    button[2] = 1'b0;
    repeat (10) tick();

    // Long press on channel 3.
    p_at = -1; l_at = -1; nlong = 0;
    button[3] = 1'b1;
    for (int i = 1; i <= 36; i++) begin
      tick();
      if (push[3]) p_at = i;
      if (long[3]) begin l_at = i; nlong++; end
    end
    check("long_push_edge", 32'(p_at), 6);
    check("long_delay", 32'(l_at - p_at), LG);
    check("long_once", 32'(nlong), 1);
    button[3] = 1'b0;
    repeat (5) tick();
    check("long_rel_early", 32'(release_pulse), 0);
    tick();
    check("long_release", 32'(release_pulse), 32'h8);
    check("long_level", 32'(level), 0);
    repeat (4) tick();

    // Asynchronous reset mid-window: ch1 pressed, ch0 two samples into its window.
    button[1] = 1'b1;
    repeat (10) tick();
    button[0] = 1'b1;
    repeat (4) tick();
    #3 reset = 1'b0;
    #1;
    check("arst_level", 32'(level), 0);
    check("arst_push", 32'(push), 0);
    repeat (2) tick();
    @(negedge ck);
    reset = 1'b1;
    repeat (5) tick();
    check("arst_push_early", 32'(push), 0);
    tick();
    check("arst_push", 32'(push), 32'h3);
    button = '0;
    repeat (10) tick();

    // Random stimulus: per-channel hold times, sub-cycle glitches, one mid-run reset.
    for (int t = 0; t < 1500; t++) begin
      for (int c = 0; c < N; c++) begin
        if (hold_left[c] == 0) begin
          button[c] = ($urandom_range(0, 1) == 1);
          hold_left[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5)
                                                     : $urandom_range(5, 40);
        end
        hold_left[c]--;
      end
      if ($urandom_range(0, 7) == 0) begin
        cnt = $urandom_range(0, N - 1);
        #2 button[cnt] = ~button[cnt];
        #2 button[cnt] = ~button[cnt];
      end
      if (t == 700) begin
        #2 reset = 1'b0;
        #1 check("rand_arst_level", 32'(level), 0);
        repeat (2) tick();
        @(negedge ck);
        reset = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
